// File: rtl/cmd_sched.sv
// Command queue between the UART wrapper and the command processor, with host flush.
// Define CMD_SCHED_ACK_EN to build the ACK/NAK response transmitter and its intake backpressure.
module cmd_sched #(
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  ACK_BYTE  = 8'hA5,
    parameter logic [7:0]  NAK_BYTE  = 8'h5A,
    parameter logic [15:0] FLUSH_CMD = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            cmd_in,
    input  logic                   cmd_rdy_in,
    output logic                   clr_cmd_rdy_in,
    output logic [15:0]            cmd_out,
    output logic                   cmd_rdy_out,
    input  logic                   clr_cmd_rdy_out,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovfl
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          intake;
    logic          is_flush;
    logic          pop;
    logic          push;
    logic          drop;

    assign pop            = clr_cmd_rdy_out && (count != '0);
    assign is_flush       = intake && (cmd_in == FLUSH_CMD);
    // A full queue still accepts when the head leaves in the same cycle.
    assign push           = intake && !is_flush && ((count != FULL) || pop);
    assign drop           = intake && !is_flush && (count == FULL) && !pop;
    assign clr_cmd_rdy_in = intake;
    assign cmd_out        = mem[rd_ptr];
    assign cmd_rdy_out    = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovfl   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (is_flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= cmd_in;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop) count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            if (drop) ovfl <= 1'b1;
        end
    end

`ifdef CMD_SCHED_ACK_EN
    typedef enum logic {T_IDLE = 1'b0, T_WAIT = 1'b1} tx_state_t;

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic       resp_pend;
    logic [7:0] resp_byte;
    logic [7:0] tx_hold;
    logic       launch;

    assign intake = cmd_rdy_in && !resp_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= T_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            T_IDLE:  if (resp_pend) state_nxt = T_WAIT;
            T_WAIT:  if (tx_done) state_nxt = T_IDLE;
            default: state_nxt = T_IDLE;
        endcase
    end

    always_comb begin
        launch  = 1'b0;
        trmt    = 1'b0;
        tx_data = tx_hold;
        if (state == T_IDLE && resp_pend) begin
            launch  = 1'b1;
            trmt    = 1'b1;
            tx_data = resp_byte;
        end
    end

    // Launch and intake never coincide: intake needs resp_pend low, launch needs it high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_pend <= 1'b0;
            resp_byte <= '0;
            tx_hold   <= '0;
        end else begin
            if (launch) begin
                resp_pend <= 1'b0;
                tx_hold   <= resp_byte;
            end
            if (intake) begin
                resp_pend <= 1'b1;
                resp_byte <= drop ? NAK_BYTE : ACK_BYTE;
            end
        end
    end
`else
    logic unused_in;

    assign intake    = cmd_rdy_in;
    assign trmt      = 1'b0;
    assign tx_data   = 8'h00;
    assign unused_in = ^{tx_done, ACK_BYTE, NAK_BYTE};
`endif

endmodule

// File: tb/tb_cmd_sched.sv
// Bench for cmd_sched: directed vector table, corner-case sequences and random traffic
// checked against a queue-based reference model.
module tb_cmd_sched;

`ifdef CMD_SCHED_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd_in = '0;
    logic        cmd_rdy_in = 1'b0;
    logic        clr_cmd_rdy_in;
    logic [15:0] cmd_out;
    logic        cmd_rdy_out;
    logic        clr_cmd_rdy_out = 1'b0;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic [2:0]  count;
    logic        ovfl;

    cmd_sched dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_in(cmd_in), .cmd_rdy_in(cmd_rdy_in), .clr_cmd_rdy_in(clr_cmd_rdy_in),
        .cmd_out(cmd_out), .cmd_rdy_out(cmd_rdy_out), .clr_cmd_rdy_out(clr_cmd_rdy_out),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .count(count), .ovfl(ovfl)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: queue contents, sticky overflow, one pending response and a busy transmitter.
    logic [15:0] q[$];
    bit          m_ovfl, m_pend, m_busy;
    logic [7:0]  m_pbyte, m_hold;
    int          busy_cnt = 0;
    int          done_dly = 3;
    bit          auto_done = 1'b1;
    bit          rand_dly = 1'b0;
    int          n_clr = 0;
    int          n_trmt = 0;
    logic [7:0]  last_tx = 8'h00;

    typedef struct {
        bit          rdy;
        logic [15:0] cmd;
        bit          pop;
        bit          done;
        bit          e_clr;
        bit          e_crdy;
        logic [2:0]  e_cnt;
        logic [15:0] e_out;
        bit          e_trmt;
        logic [7:0]  e_tx;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovfl   = 1'b0;
        m_pend   = 1'b0;
        m_busy   = 1'b0;
        m_pbyte  = 8'h00;
        m_hold   = 8'h00;
        busy_cnt = 0;
    endtask

    task automatic step(input bit rdy, input logic [15:0] c, input bit p, output bit acc);
        bit          intake, flush, popm, can, e_trmt;
        logic [7:0]  byt, e_tx;
        logic [15:0] tmp;
        cmd_rdy_in      = rdy;
        cmd_in          = c;
        clr_cmd_rdy_out = p;
        if (ACK) tx_done = auto_done && m_busy && (busy_cnt >= done_dly);
        else     tx_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        intake = rdy && !(ACK && m_pend);
        e_trmt = ACK && !m_busy && m_pend;
        e_tx   = !ACK ? 8'h00 : (e_trmt ? m_pbyte : m_hold);
        check("clr_cmd_rdy_in", 32'(clr_cmd_rdy_in), 32'(intake));
        check("cmd_rdy_out", 32'(cmd_rdy_out), 32'(q.size() != 0));
        check("count", 32'(count), 32'(q.size()));
        if (q.size() != 0) check("cmd_out", 32'(cmd_out), 32'(q[0]));
        check("trmt", 32'(trmt), 32'(e_trmt));
        check("tx_data", 32'(tx_data), 32'(e_tx));
        check("ovfl", 32'(ovfl), 32'(m_ovfl));
        if (clr_cmd_rdy_in) n_clr++;
        if (trmt) begin
            n_trmt++;
            last_tx = tx_data;
        end
        acc = intake;
        @(posedge clk);
        popm  = p && (q.size() != 0);
        flush = intake && (c == 16'h0000);
        can   = (q.size() < DEPTH) || popm;
        byt   = 8'hA5;
        if (flush) q.delete();
        else begin
            if (popm) tmp = q.pop_front();
            if (intake) begin
                if (can) q.push_back(c);
                else begin
                    m_ovfl = 1'b1;
                    byt    = 8'h5A;
                end
            end
        end
        if (e_trmt) begin
            m_hold   = m_pbyte;
            m_pend   = 1'b0;
            m_busy   = 1'b1;
            busy_cnt = 0;
            done_dly = rand_dly ? int'($urandom_range(0, 12)) : 3;
        end else if (m_busy) begin
            if (tx_done) m_busy = 1'b0;
            else busy_cnt++;
        end
        if (ACK && intake) begin
            m_pend  = 1'b1;
            m_pbyte = byt;
        end
        #1;
    endtask

    task automatic send(input logic [15:0] c, input bit p);
        bit acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) step(1'b1, c, p, acc);
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic settle();
        bit a;
        int k = 0;
        while ((m_pend || m_busy) && k < 100) begin
            step(1'b0, 16'h0, 1'b0, a);
            k++;
        end
        check("settle_idle", 32'(m_pend || m_busy), 32'd0);
    endtask

    task automatic do_reset();
        cmd_rdy_in      = 1'b0;
        clr_cmd_rdy_out = 1'b0;
        tx_done         = 1'b0;
        rst_n           = 1'b0;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_trmt", 32'(trmt), 32'd0);
        check("rst_ovfl", 32'(ovfl), 32'd0);
        check("rst_cmd_rdy_out", 32'(cmd_rdy_out), 32'd0);
        check("rst_clr_cmd_rdy_in", 32'(clr_cmd_rdy_in), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_cmd_out", 32'(cmd_out), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit a;
        bit have;
        int idx;
        logic [15:0] c;

        // rdy cmd pop done | clr crdy cnt out trmt tx
        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1234, 1'b1, 8'hA5};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h1234, 1'b0, 8'hA5};
        tbl[4]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h1234, 1'b0, 8'hA5};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'h1234, 1'b1, 8'hA5};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'hABCD, 1'b0, 8'hA5};
        tbl[7]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 16'hABCD, 1'b0, 8'hA5};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 8'hA5};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 8'hA5};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 8'hA5};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 8'hA5};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            cmd_rdy_in      = tbl[i].rdy;
            cmd_in          = tbl[i].cmd;
            clr_cmd_rdy_out = tbl[i].pop;
            tx_done         = tbl[i].done;
            @(negedge clk);
            check($sformatf("vec%0d_clr", i), 32'(clr_cmd_rdy_in), 32'(tbl[i].e_clr));
            check($sformatf("vec%0d_crdy", i), 32'(cmd_rdy_out), 32'(tbl[i].e_crdy));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_crdy) check($sformatf("vec%0d_out", i), 32'(cmd_out), 32'(tbl[i].e_out));
            check($sformatf("vec%0d_trmt", i), 32'(trmt), 32'(tbl[i].e_trmt && ACK));
            check($sformatf("vec%0d_tx", i), 32'(tx_data), 32'(ACK ? tbl[i].e_tx : 8'h00));
            check($sformatf("vec%0d_ovfl", i), 32'(ovfl), 32'd0);
            @(posedge clk);
            #1;
        end

        // Overflow: fifth command into a full queue is dropped with a NAK.
        do_reset();
        auto_done = 1'b1;
        for (int i = 1; i <= 5; i++) send(16'(i), 1'b0);
        settle();
        check("full_count", 32'(count), 32'd4);
        check("full_ovfl", 32'(ovfl), 32'd1);
        check("nak_byte", 32'(last_tx), 32'(ACK ? 8'h5A : 8'h00));
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("pop_order%0d", i), 32'(cmd_out), 32'(i));
            step(1'b0, 16'h0, 1'b1, a);
        end
        check("drained_rdy", 32'(cmd_rdy_out), 32'd0);

        // Reset while a response is in flight and two entries are held.
        auto_done = 1'b0;
        send(16'h0031, 1'b0);
        send(16'h0032, 1'b0);
        step(1'b0, 16'h0, 1'b0, a);
        step(1'b0, 16'h0, 1'b0, a);
        check("pre_rst_count", 32'(count), 32'd2);
        do_reset();
        auto_done = 1'b1;
        send(16'h0077, 1'b0);
        settle();
        check("resume_out", 32'(cmd_out), 32'h0077);
        check("resume_count", 32'(count), 32'd1);

        // Full queue with a pop in the intake cycle: accepted, no NAK.
        step(1'b0, 16'h0, 1'b1, a);
        for (int i = 5; i <= 8; i++) send(16'(i), 1'b0);
        settle();
        step(1'b1, 16'h0009, 1'b1, a);
        check("pushpop_accept", 32'(a), 32'd1);
        settle();
        check("pushpop_count", 32'(count), 32'd4);
        check("pushpop_ovfl", 32'(ovfl), 32'd0);
        check("pushpop_ack", 32'(last_tx), 32'(ACK ? 8'hA5 : 8'h00));
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, a);
        check("pushpop_last", 32'(cmd_out), 32'h0009);

        // Flush with a simultaneous pop while three entries are held.
        send(16'h000A, 1'b0);
        send(16'h000B, 1'b0);
        settle();
        check("flush_pre_count", 32'(count), 32'd3);
        step(1'b1, 16'h0000, 1'b1, a);
        check("flush_count", 32'(count), 32'd0);
        check("flush_rdy", 32'(cmd_rdy_out), 32'd0);
        settle();
        check("flush_ack", 32'(last_tx), 32'(ACK ? 8'hA5 : 8'h00));

        // Transmitter stalled for 200 cycles with three commands waiting.
        auto_done = 1'b0;
        n_clr  = 0;
        n_trmt = 0;
        idx    = 0;
        for (int k = 0; k < 200; k++) begin
            step(idx < 3, 16'(16'h0021 + idx), 1'b0, a);
            if (a) idx++;
        end
        check("stall_clr", 32'(n_clr), 32'(ACK ? 2 : 3));
        check("stall_trmt", 32'(n_trmt), 32'(ACK ? 1 : 0));
        auto_done = 1'b1;
        for (int k = 0; k < 100 && idx < 3; k++) begin
            step(1'b1, 16'(16'h0021 + idx), 1'b0, a);
            if (a) idx++;
        end
        settle();
        check("stall_clr_total", 32'(n_clr), 32'd3);
        check("stall_trmt_total", 32'(n_trmt), 32'(ACK ? 3 : 0));

        // Random traffic against the model.
        rand_dly = 1'b1;
        have     = 1'b0;
        c        = 16'h0;
        for (int k = 0; k < 3000; k++) begin
            if (!have && ($urandom_range(0, 2) == 0)) begin
                have = 1'b1;
                c    = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
            end
            step(have, c, ($urandom_range(0, 2) == 0), a);
            if (a) have = 1'b0;
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
